// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: sprite DMA state encoding and bus constants.
package ppu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE,
      DONE
   } oam_dma_state_t;

   localparam int          OAM_WIDTH    = 8;
   localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine for $4014: halts the CPU and copies one 256-byte page into
// OAM, starting at the OAMADDR captured when the page write is accepted.
module oam_dma
   import ppu_pkg::*;
#(
   parameter int OAM_W  = OAM_WIDTH,
   parameter int PAGE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_clk_en,
   input  logic              reg_wr,
   input  logic [PAGE_W-1:0] reg_data,
   input  logic [OAM_W-1:0]  oam_base,
   output logic              cpu_halt,
   output logic [15:0]       mem_addr,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic [OAM_W-1:0]  oam_addr,
   output logic              oam_we,
   output logic [7:0]        oam_data,
   output logic              dma_active,
   output logic              dma_done
);

   oam_dma_state_t    state, state_nxt;
   logic              parity;
   logic [PAGE_W-1:0] page;
   logic [OAM_W-1:0]  base;
   logic [OAM_W-1:0]  index;
   logic [7:0]        latch;

   logic halt_nxt, re_nxt, we_nxt, done_nxt;

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      halt_nxt  = 1'b0;
      re_nxt    = 1'b0;
      we_nxt    = 1'b0;
      done_nxt  = 1'b0;

      unique case (state)
         IDLE:    if (reg_wr) state_nxt = HALT;
         HALT:    state_nxt = parity ? ALIGN : READ;
         ALIGN:   state_nxt = READ;
         READ:    state_nxt = WRITE;
         WRITE:   state_nxt = (index == '1) ? DONE : READ;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Outputs are registered decodes of the state being entered.
      unique case (state_nxt)
         HALT, ALIGN: halt_nxt = 1'b1;
         READ: begin
            halt_nxt = 1'b1;
            re_nxt   = 1'b1;
         end
         WRITE: begin
            halt_nxt = 1'b1;
            we_nxt   = 1'b1;
         end
         DONE:    done_nxt = 1'b1;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         parity     <= 1'b0;
         cpu_halt   <= 1'b0;
         dma_active <= 1'b0;
         mem_re     <= 1'b0;
         oam_we     <= 1'b0;
         dma_done   <= 1'b0;
      end else if (cpu_clk_en) begin
         state      <= state_nxt;
         parity     <= ~parity;
         cpu_halt   <= halt_nxt;
         dma_active <= halt_nxt;
         mem_re     <= re_nxt;
         oam_we     <= we_nxt;
         dma_done   <= done_nxt;
      end
   end

   // Transfer datapath; page and base are frozen at acceptance so later
   // $4014 or OAMADDR writes cannot disturb a running copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         page  <= '0;
         base  <= '0;
         index <= '0;
         latch <= '0;
      end else if (cpu_clk_en) begin
         unique case (state)
            IDLE: begin
               if (reg_wr) begin
                  page  <= reg_data;
                  base  <= oam_base;
                  index <= '0;
               end
            end
            READ:    latch <= mem_rdata;
            WRITE:   index <= index + 1'b1;
            default: ;
         endcase
      end
   end

   assign mem_addr = 16'({page, index});
   assign oam_addr = base + index;
   assign oam_data = latch;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: table of whole-page transfers plus
// hand-written sequences for mid-transfer rewrite and mid-transfer reset.
module tb_oam_dma;
   import ppu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cpu_clk_en = 1'b0;
   logic        reg_wr = 1'b0;
   logic [7:0]  reg_data = '0;
   logic [7:0]  oam_base = '0;
   logic        cpu_halt, mem_re, oam_we, dma_active, dma_done;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata, oam_addr, oam_data;

   logic [7:0]  mem [65536];
   logic [7:0]  oam [256];

   assign mem_rdata = mem[mem_addr];

   oam_dma #(.OAM_W(8), .PAGE_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_clk_en(cpu_clk_en),
      .reg_wr(reg_wr), .reg_data(reg_data), .oam_base(oam_base),
      .cpu_halt(cpu_halt), .mem_addr(mem_addr), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .oam_addr(oam_addr), .oam_we(oam_we),
      .oam_data(oam_data), .dma_active(dma_active), .dma_done(dma_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // CPU strobe: one master clock high, then gap-1 low; gap fixed or random.
   int gap_lo = 6;
   int gap_hi = 6;
   initial begin : gen
      int g;
      forever begin
         g = (gap_lo == gap_hi) ? gap_lo : int'($urandom_range(gap_hi, gap_lo));
         @(posedge clk); #1 cpu_clk_en = 1'b1;
         @(posedge clk); #1 cpu_clk_en = 1'b0;
         repeat (g - 2) @(posedge clk);
      end
   end

   // Enable edges since reset; after edge N the DUT parity is N%2.
   int edges;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) edges <= 0;
      else if (cpu_clk_en) edges <= edges + 1;

   // Monitor and scoreboard, sampled on the falling edge.
   logic [15:0] sb [$];
   logic [7:0]  cur_page;
   logic [7:0]  rd_idx;
   int          halt_cnt, we_cnt, rd_cnt, done_cnt;
   bit          stab_on = 1'b0;
   logic        prev_en = 1'b0;
   logic [20:0] snap_ctl;
   logic [15:0] snap_addr;

   always @(negedge clk) begin
      logic [15:0] e;
      if (oam_we) oam[oam_addr] = oam_data;
      if (rst_n && cpu_clk_en) begin
         if (cpu_halt) halt_cnt++;
         if (dma_done) done_cnt++;
         if (mem_re) begin
            check("rd_page", 32'(mem_addr[15:8]), 32'(cur_page));
            check("rd_index", 32'(mem_addr[7:0]), 32'(rd_idx));
            rd_idx++;
            rd_cnt++;
         end
         if (oam_we) begin
            we_cnt++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("oam_wr_addr", 32'(oam_addr), 32'(e[15:8]));
               check("oam_wr_data", 32'(oam_data), 32'(e[7:0]));
            end
         end
      end
      if (stab_on && rst_n && !prev_en) begin
         check("stable_ctl", 32'({cpu_halt, dma_active, mem_re, oam_we, dma_done, oam_addr, oam_data}),
               32'(snap_ctl));
         check("stable_addr", 32'(mem_addr), 32'(snap_addr));
      end
      snap_ctl  = {cpu_halt, dma_active, mem_re, oam_we, dma_done, oam_addr, oam_data};
      snap_addr = mem_addr;
      prev_en   = cpu_clk_en;
   end

   task automatic start_dma(input logic [7:0] page, input logic [7:0] base, input int odd);
      logic [7:0] a, k;
      cur_page = page;
      rd_idx   = '0;
      halt_cnt = 0; we_cnt = 0; rd_cnt = 0; done_cnt = 0;
      sb.delete();
      for (int i = 0; i < 256; i++) begin
         k = 8'(i);
         a = base + k;
         oam[a] = ~mem[{page, k}];
         sb.push_back({a, mem[{page, k}]});
      end
      do @(negedge clk); while (!(cpu_clk_en && ((edges + 1) % 2 == odd)));
      reg_data = page;
      oam_base = base;
      reg_wr   = 1'b1;
      @(posedge clk); #2 reg_wr = 1'b0;
      oam_base = ~base;
   endtask

   task automatic wait_done(input bit poke_done);
      int  t = 0;
      bit  seen = 1'b0;
      int  budget = 520 * gap_hi + 200;
      while (!seen && t < budget) begin
         @(negedge clk);
         t++;
         if (dma_done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'd1);
      if (seen && poke_done) begin
         while (!cpu_clk_en) @(negedge clk);
         reg_data = 8'h09;
         reg_wr   = 1'b1;
         @(posedge clk); #2 reg_wr = 1'b0;
      end
      repeat (gap_hi * 4) @(negedge clk);
   endtask

   task automatic check_xfer(input logic [7:0] page, input logic [7:0] base, input int halt_exp);
      logic [7:0] k;
      check("halt_cycles", 32'(halt_cnt), 32'(halt_exp));
      check("we_cycles", 32'(we_cnt), 32'd256);
      check("re_cycles", 32'(rd_cnt), 32'd256);
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("sb_drained", 32'(sb.size()), 32'd0);
      check("halt_after", 32'({cpu_halt, dma_active}), 32'd0);
      for (int i = 0; i < 256; i++) begin
         k = 8'(i);
         check("oam_content", 32'(oam[8'(base + k)]), 32'(mem[{page, k}]));
      end
   endtask

   typedef struct {
      logic [7:0] page;
      logic [7:0] base;
      int         odd;
      bit         rnd_gap;
      int         halt_exp;
   } vec_t;

   initial begin : watchdog
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t       vecs [6];
      logic [7:0] k;
      int         t;
      int         we_before;

      vecs[0] = '{8'h02, 8'h00, 0, 1'b0, 513};
      vecs[1] = '{8'h02, 8'h00, 1, 1'b0, 514};
      vecs[2] = '{8'h03, 8'hF0, 0, 1'b0, 513};
      vecs[3] = '{8'hFF, 8'h80, 1, 1'b0, 514};
      vecs[4] = '{8'h02, 8'h00, 0, 1'b1, 513};
      vecs[5] = '{8'h03, 8'hF0, 1, 1'b1, 514};

      for (int a = 0; a < 65536; a++) begin
         case (a[15:8])
            8'h02:   mem[a] = a[7:0] ^ 8'h5A;
            8'h03:   mem[a] = a[7:0];
            8'h07:   mem[a] = 8'hEE;
            default: mem[a] = a[15:8] + a[7:0];
         endcase
      end

      // Reset state
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctl", 32'({cpu_halt, dma_active, mem_re, oam_we, dma_done}), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_oam", 32'({oam_addr, oam_data}), 32'd0);
      rst_n = 1'b1;

      // Idle, and a write without the CPU strobe, must not start a transfer.
      repeat (40) @(negedge clk);
      check("idle_halt", 32'(cpu_halt), 32'd0);
      do @(negedge clk); while (cpu_clk_en);
      reg_data = 8'h02;
      reg_wr   = 1'b1;
      @(posedge clk); #2 reg_wr = 1'b0;
      repeat (40) @(negedge clk);
      check("wr_no_en_halt", 32'({cpu_halt, dma_active}), 32'd0);

      // Table of whole-page transfers
      for (int v = 0; v < 6; v++) begin
         gap_lo  = vecs[v].rnd_gap ? 12 : 6;
         gap_hi  = vecs[v].rnd_gap ? 20 : 6;
         stab_on = vecs[v].rnd_gap;
         start_dma(vecs[v].page, vecs[v].base, vecs[v].odd);
         wait_done(1'b0);
         stab_on = 1'b0;
         check_xfer(vecs[v].page, vecs[v].base, vecs[v].halt_exp);
         if (vecs[v].base == 8'hF0) begin
            check("wrap_f0", 32'(oam[8'hF0]), 32'h00);
            check("wrap_00", 32'(oam[8'h00]), 32'h10);
            check("wrap_ef", 32'(oam[8'hEF]), 32'hFF);
         end
      end
      gap_lo = 6;
      gap_hi = 6;

      // Rewrite of $4014 at byte 40 and in the DONE cycle is ignored.
      start_dma(8'h02, 8'h00, 0);
      t = 0;
      while (we_cnt < 40 && t < 5000) begin @(negedge clk); t++; end
      check("reach_byte40", 32'(we_cnt), 32'd40);
      while (!cpu_clk_en) @(negedge clk);
      reg_data = 8'h07;
      oam_base = 8'h55;
      reg_wr   = 1'b1;
      @(posedge clk); #2 reg_wr = 1'b0;
      wait_done(1'b1);
      check_xfer(8'h02, 8'h00, 513);
      repeat (30 * 6) @(negedge clk);
      check("no_restart", 32'({cpu_halt, dma_active, mem_re, oam_we}), 32'd0);

      // Reset during the WRITE of index 100
      start_dma(8'h02, 8'h00, 0);
      t = 0;
      while (!(oam_we && oam_addr == 8'd100) && t < 5000) begin @(negedge clk); t++; end
      check("reach_idx100", 32'({oam_we, oam_addr}), 32'({1'b1, 8'd100}));
      #3 rst_n = 1'b0;
      #1;
      check("midrst_ctl", 32'({cpu_halt, dma_active, mem_re, oam_we, dma_done}), 32'd0);
      check("midrst_oam", 32'({oam_addr, oam_data}), 32'd0);
      we_before = we_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_hold_we", 32'(oam_we), 32'd0);
      end
      for (int i = 0; i < 100; i++) begin
         k = 8'(i);
         check("oam_retained", 32'(oam[k]), 32'(mem[{8'h02, k}]));
      end
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check("post_rst_we", 32'(we_cnt), 32'(we_before));
      check("post_rst_idle", 32'(cpu_halt), 32'd0);
      start_dma(8'h03, 8'h00, 1);
      wait_done(1'b0);
      check_xfer(8'h03, 8'h00, 514);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-side sprite DMA engine for writes to $4014; it is the initiator that fills the PPU OAM.
- On a page write it halts the CPU.
- It then copies 256 bytes from CPU address space $XX00-$XXFF into OAM, starting at the current OAMADDR and wrapping modulo 256.
- It sits between the CPU bus arbiter and the OAM write port, and drives OAM addr/we/data in place of the $2004 path while active.

Parameters:
- OAM_W, 8, OAM address width; transfer length is 2**OAM_W bytes.
- PAGE_W, 8, width of the $4014 page register (source high address byte).

Ports:
- clk  in  1  master clock
- rst_n  in  1  asynchronous reset, active low
- cpu_clk_en  in  1  CPU cycle strobe (master/12); all state advances only when high
- reg_wr  in  1  CPU write to $4014 this CPU cycle
- reg_data  in  PAGE_W  value written to $4014 (source page)
- oam_base  in  OAM_W  current OAMADDR; sampled at transfer start
- cpu_halt  out  1  stalls the CPU core while DMA owns the bus
- mem_addr  out  16  CPU-bus read address
- mem_re  out  1  CPU-bus read request
- mem_rdata  in  8  CPU-bus read data; valid by the end of the CPU cycle in which mem_re is high
- oam_addr  out  OAM_W  OAM write address
- oam_we  out  1  OAM write enable
- oam_data  out  8  OAM write data
- dma_active  out  1  high from acceptance until the last write completes
- dma_done  out  1  one-CPU-cycle pulse in the cycle after the last write

Behaviour:
- Reset values: all outputs are 0; state IDLE; parity 0; index 0; latches 0. Reset is honoured mid-transfer: the block returns to IDLE at once, cpu_halt and oam_we deassert, and no further OAM writes occur.
- Parity: a 1-bit cycle-parity counter toggles on every cpu_clk_en. Even = 0.
- State IDLE: on cpu_clk_en with reg_wr, latch page = reg_data, base = oam_base, index = 0, then go to HALT.
- State HALT: cpu_halt = 1, dma_active = 1 for one CPU cycle. If parity is odd at this cycle, go to ALIGN; otherwise go to READ.
- State ALIGN: one idle CPU cycle with the halt held, then go to READ.
- State READ: mem_re = 1 and mem_addr = {page, index}. On cpu_clk_en, capture mem_rdata into the data latch, then go to WRITE.
- State WRITE: oam_we = 1, oam_addr = base + index (mod 2**OAM_W), oam_data = latch. oam_we is held for the whole CPU cycle; repeated OAM writes within that cycle are idempotent. On cpu_clk_en, index increments.
  - If index was 2**OAM_W-1, go to DONE.
  - Otherwise go to READ.
- State DONE: dma_done = 1 for one CPU cycle. cpu_halt and dma_active are 0. Return to IDLE.
- Total halt length is 1 + align + 512 CPU cycles, i.e. 513 (even start) or 514 (odd start).
- cpu_halt, dma_active, mem_re and oam_we are all registered state decodes. They change only on cpu_clk_en edges.
- reg_wr while state is not IDLE is ignored: no restart and no page change. reg_wr in the DONE cycle is also ignored.
- oam_base changes after acceptance have no effect on the running transfer.
- Index and OAM address wrap silently; page FF reads $FF00-$FFFF.
- Cycles with cpu_clk_en low hold every register and output steady.

Decomposition:
- Shared package ppu_pkg holds the state enum oam_dma_state_t {IDLE, HALT, ALIGN, READ, WRITE, DONE}, the constant OAM_WIDTH = 8, and the constant DMA_REG_ADDR = 16'h4014.
- Single module; no sub-module is warranted.
- Top level muxes the OAM port between $2004 and this block on dma_active.

Test Plan:
1. Even-parity start, reg_data=8'h02, oam_base=0, memory[$02xx]=xx^8'h5A -> cpu_halt high exactly 513 CPU cycles; OAM[i]=i^8'h5A for all 256 entries; one dma_done pulse.
2. Same transfer started on an odd cycle -> 514 halt cycles (ALIGN visited once); OAM contents identical to scenario 1.
3. oam_base=8'hF0, page 8'h03 with memory[$03xx]=xx -> OAM[8'hF0]=0, OAM[8'h00]=8'h10, OAM[8'hEF]=8'hFF; exactly 256 oam_we cycles.
4. Second reg_wr with reg_data=8'h07 at byte 40 of a page-02 transfer -> ignored; all mem_addr stay in $0200-$02FF; total length unchanged.
5. rst_n low during WRITE of index 100 -> outputs 0 immediately; no oam_we thereafter; OAM[0..99] retain DMA data; a new reg_wr after reset restarts cleanly at index 0.
6. cpu_clk_en with random gaps of 12-20 master clocks -> same cycle counts in CPU cycles as scenarios 1 and 2; outputs stable between enables.
